// File: rtl/audio_nios_pio_key.sv
// audio_nios_pio_key: Avalon-MM key/switch input port.
// Each pin is synchronized, debounced over a programmable number of cycles,
// and the debounced level is watched for edges that latch into a
// write-1-to-clear capture register feeding a maskable level interrupt.
//
// Register map (word addresses):
//   0 DATA     RO  debounced pin state
//   1 PERIOD   RW  debounce period in cycles (0 behaves like 1)
//   2 IRQMASK  RW  per-bit interrupt enable
//   3 EDGECAP  R/W1C captured edges
module audio_nios_pio_key #(
  parameter int              WIDTH            = 4,
  parameter int              EDGE             = 1,
  parameter logic [15:0]     DEBOUNCE_DEFAULT = 16'd50000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_prev;
  logic [15:0]      period;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [15:0]      cnt [WIDTH];

  logic             wr_en;
  logic             period_wr;
  logic [WIDTH-1:0] cap_clear;
  logic [WIDTH-1:0] edge_event;
  logic [15:0]      period_eff;
  logic [15:0]      cnt_last;

  assign wr_en      = chipselect & ~write_n;
  assign period_wr  = wr_en && (address == ADDR_PERIOD);
  assign cap_clear  = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // A zero period would never let the counter match, so treat it as one cycle.
  assign period_eff = (period == 16'd0) ? 16'd1 : period;
  assign cnt_last   = period_eff - 16'd1;

  // Two-flop synchronizer; sync2 is the only copy of the pins used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept a new level only after it has differed from d for a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d <= IDLE_LEVEL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (period_wr) begin
          cnt[i] <= 16'd0;
        end else if (sync2[i] != d[i]) begin
          if (cnt[i] == cnt_last) begin
            d[i]   <= sync2[i];
            cnt[i] <= 16'd0;
          end else begin
            cnt[i] <= cnt[i] + 16'd1;
          end
        end else begin
          cnt[i] <= 16'd0;
        end
      end
    end
  end

  // Previous debounced level, used only for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_prev <= IDLE_LEVEL;
    end else begin
      d_prev <= d;
    end
  end

  // Select which debounced transitions count as a captured edge.
  always_comb begin
    edge_event = '0;
    case (EDGE)
      0:       edge_event = d & ~d_prev;
      1:       edge_event = ~d & d_prev;
      default: edge_event = d ^ d_prev;
    endcase
  end

  // Software-visible control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period  <= DEBOUNCE_DEFAULT;
      irqmask <= '0;
    end else if (wr_en) begin
      if (address == ADDR_PERIOD) begin
        period <= writedata[15:0];
      end
      if (address == ADDR_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  // Edge capture with write-1-to-clear; a new edge on the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecap <= '0;
    end else begin
      edgecap <= (edgecap & ~cap_clear) | edge_event;
    end
  end

  // Zero-wait-state read mux, not gated by chipselect.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = d;
      ADDR_PERIOD:  readdata[15:0]      = period;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      default:      readdata            = 32'd0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule
